// File: rtl/encoder_frame_ctrl.sv
// rtl/encoder_frame_ctrl.sv - frame sequencer feeding SIGNAL, data, tail and pad words to the convolutional encoder
module encoder_frame_ctrl #(
    parameter int WIDTH   = 24,
    parameter int NW_BITS = 12,
    parameter int NP_BITS = 8
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_rate,
    input  logic [11:0]        cmd_length,
    input  logic [NW_BITS-1:0] cmd_nwords,
    input  logic [NP_BITS-1:0] cmd_npad,
    input  logic [WIDTH-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [WIDTH-1:0]   m_axis_tdata,
    output logic [3:0]         m_axis_tuser,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic               busy,
    output logic               err_short
);

    localparam logic [3:0] RATE_6M = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGNAL,
        ST_DATA,
        ST_TAIL,
        ST_PAD
    } state_t;

    state_t state, state_n;

    logic [3:0]         rate_q;
    logic [11:0]        length_q;
    logic [NW_BITS-1:0] wcnt;
    logic [NP_BITS-1:0] pcnt;
    logic               flush;
    logic               cmd_ready_q;

    logic               load_ok;
    logic               cmd_fire;
    logic               s_fire;
    logic               ld;
    logic [WIDTH-1:0]   ld_data;
    logic [3:0]         ld_user;
    logic               ld_last;
    logic               wcnt_dec;
    logic               pcnt_dec;
    logic               set_err;
    logic               set_flush;

    logic [17:0]        sig_field;
    logic [WIDTH-1:0]   sig_word;

    assign load_ok       = !m_axis_tvalid || m_axis_tready;
    assign cmd_ready     = cmd_ready_q;
    assign busy          = (state != ST_IDLE);
    // Once a short frame is detected the remaining slots are filled locally, so upstream is held off.
    assign s_axis_tready = (state == ST_DATA) && !flush && load_ok;
    assign cmd_fire      = cmd_valid && cmd_ready_q;
    assign s_fire        = s_axis_tvalid && s_axis_tready;

    // SIGNAL layout: rate, reserved zero, length, even parity over the first 17 bits.
    assign sig_field = {^{length_q, 1'b0, rate_q}, length_q, 1'b0, rate_q};

    always_comb begin
        sig_word        = '0;
        sig_word[17:0]  = sig_field;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        ld        = 1'b0;
        ld_data   = '0;
        ld_user   = rate_q;
        ld_last   = 1'b0;
        wcnt_dec  = 1'b0;
        pcnt_dec  = 1'b0;
        set_err   = 1'b0;
        set_flush = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_n = ST_SIGNAL;
                end
            end
            ST_SIGNAL: begin
                if (load_ok) begin
                    ld      = 1'b1;
                    ld_data = sig_word;
                    ld_user = RATE_6M;
                    state_n = (wcnt == '0) ? ST_TAIL : ST_DATA;
                end
            end
            ST_DATA: begin
                if (flush) begin
                    if (load_ok) begin
                        ld       = 1'b1;
                        wcnt_dec = 1'b1;
                        if (wcnt == NW_BITS'(1)) begin
                            state_n = ST_TAIL;
                        end
                    end
                end else if (s_fire) begin
                    ld       = 1'b1;
                    ld_data  = s_axis_tdata;
                    wcnt_dec = 1'b1;
                    if (wcnt == NW_BITS'(1)) begin
                        state_n = ST_TAIL;
                    end else if (s_axis_tlast) begin
                        set_err   = 1'b1;
                        set_flush = 1'b1;
                    end
                end
            end
            ST_TAIL: begin
                if (load_ok) begin
                    ld      = 1'b1;
                    ld_last = (pcnt == '0);
                    state_n = (pcnt == '0) ? ST_IDLE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (load_ok) begin
                    ld       = 1'b1;
                    pcnt_dec = 1'b1;
                    if (pcnt == NP_BITS'(1)) begin
                        ld_last = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_ready_q   <= 1'b0;
            rate_q        <= '0;
            length_q      <= '0;
            wcnt          <= '0;
            pcnt          <= '0;
            flush         <= 1'b0;
            err_short     <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            cmd_ready_q <= (state_n == ST_IDLE);
            if (cmd_fire) begin
                rate_q    <= cmd_rate;
                length_q  <= cmd_length;
                wcnt      <= cmd_nwords;
                pcnt      <= cmd_npad;
                flush     <= 1'b0;
                err_short <= 1'b0;
            end
            if (set_err) begin
                err_short <= 1'b1;
            end
            if (set_flush) begin
                flush <= 1'b1;
            end
            if (wcnt_dec) begin
                wcnt <= wcnt - NW_BITS'(1);
            end
            if (pcnt_dec) begin
                pcnt <= pcnt - NP_BITS'(1);
            end
            if (ld) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ld_data;
                m_axis_tuser  <= ld_user;
                m_axis_tlast  <= ld_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// tb/tb_encoder_frame_ctrl.sv - directed self-checking bench for encoder_frame_ctrl
module tb_encoder_frame_ctrl;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_rate;
    logic [11:0] cmd_length;
    logic [11:0] cmd_nwords;
    logic [7:0]  cmd_npad;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        s_tlast;
    logic [23:0] m_tdata;
    logic [3:0]  m_tuser;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic        err_short;

    int          n_tests;
    int          n_fail;
    int          stall_err;
    bit          rnd_ready;
    bit          stalled;
    logic [31:0] held;
    logic [31:0] got_q[$];
    logic [23:0] next_data[$];
    logic [3:0]  rates[8] = '{4'hB, 4'hF, 4'hA, 4'hE, 4'h9, 4'hD, 4'h8, 4'hC};

    encoder_frame_ctrl dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rate      (cmd_rate),
        .cmd_length    (cmd_length),
        .cmd_nwords    (cmd_nwords),
        .cmd_npad      (cmd_npad),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .busy          (busy),
        .err_short     (err_short)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic l, input logic [3:0] u, input logic [23:0] d);
        return {3'b000, l, u, d};
    endfunction

    function automatic logic [23:0] exp_sig(input logic [3:0] rate, input logic [11:0] len);
        logic [23:0] w;
        logic        p;
        w       = '0;
        w[3:0]  = rate;
        w[16:5] = len;
        p       = 1'b0;
        for (int i = 0; i < 17; i++) p = p ^ w[i];
        w[17]   = p;
        return w;
    endfunction

    // Output sink: drives m_tready at negedge, samples just after, records handshakes and stall stability.
    initial begin
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge aclk);
            m_tready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (!aresetn) begin
                stalled = 1'b0;
            end else begin
                if (stalled && (!m_tvalid || pack(m_tlast, m_tuser, m_tdata) != held)) stall_err++;
                if (m_tvalid && m_tready) got_q.push_back(pack(m_tlast, m_tuser, m_tdata));
                stalled = m_tvalid && !m_tready;
                held    = pack(m_tlast, m_tuser, m_tdata);
            end
        end
    end

    task automatic send_cmd(input logic [3:0] rate, input logic [11:0] len, input int nw, input int np);
        int t;
        bit hs;
        @(negedge aclk);
        cmd_valid  = 1'b1;
        cmd_rate   = rate;
        cmd_length = len;
        cmd_nwords = 12'(nw);
        cmd_npad   = 8'(np);
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 100) begin
            if (t > 0) @(negedge aclk);
            #1 hs = cmd_ready;
            @(posedge aclk);
            t++;
        end
        if (!hs) check("cmd_accept", 0, 1);
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic feed_word(input logic [23:0] d, input logic last);
        int t;
        bit hs;
        @(negedge aclk);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 500) begin
            if (t > 0) @(negedge aclk);
            #1 hs = s_tready;
            @(posedge aclk);
            t++;
        end
        if (!hs) check("s_accept", 0, 1);
    endtask

    task automatic run_frame(input logic [3:0] rate, input logic [11:0] len, input int nw, input int np,
                             input int short_at, input bit gaps, input bit chk_lat);
        logic [31:0] exp_q[$];
        logic [23:0] dw[$];
        int          n_feed;
        int          t;
        int          junk;
        for (int i = 0; i < nw; i++) begin
            if (next_data.size() > 0) dw.push_back(next_data.pop_front());
            else                      dw.push_back(24'($urandom));
        end
        exp_q.push_back(pack(1'b0, 4'hB, exp_sig(rate, len)));
        for (int i = 0; i < nw; i++)
            exp_q.push_back(pack(1'b0, rate, (short_at >= 0 && i > short_at) ? 24'h0 : dw[i]));
        exp_q.push_back(pack(np == 0, rate, 24'h0));
        for (int j = 0; j < np; j++) exp_q.push_back(pack(j == np - 1, rate, 24'h0));
        got_q.delete();

        send_cmd(rate, len, nw, np);
        #1;
        check("err_clear", {31'b0, err_short}, 0);
        if (chk_lat) begin
            check("sig_not_early", {31'b0, m_tvalid}, 0);
            @(negedge aclk);
            #1;
            check("sig_latency", {31'b0, m_tvalid}, 1);
            check("busy_frame", {31'b0, busy}, 1);
        end

        n_feed = (short_at >= 0) ? short_at + 1 : nw;
        for (int i = 0; i < n_feed; i++) begin
            if (gaps) begin
                int idle;
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) begin
                    @(negedge aclk);
                    s_tvalid = 1'b0;
                end
            end
            feed_word(dw[i], i == n_feed - 1);
        end

        if (short_at >= 0) begin
            @(negedge aclk);
            s_tvalid = 1'b1;
            s_tdata  = 24'hDEADBE;
            s_tlast  = 1'b0;
            junk = 0;
            t    = 0;
            while (got_q.size() < exp_q.size() && t < 2000) begin
                #1 if (s_tready) junk++;
                @(negedge aclk);
                t++;
            end
            check("short_stall", junk, 0);
            check("err_short_set", {31'b0, err_short}, 1);
        end
        @(negedge aclk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        repeat (3) @(negedge aclk);
        #2;
        check("frame_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
        check("idle_after", {31'b0, busy}, 0);
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        stall_err  = 0;
        rnd_ready  = 1'b0;
        aresetn    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_rate   = '0;
        cmd_length = '0;
        cmd_nwords = '0;
        cmd_npad   = '0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        m_tready   = 1'b1;

        #12;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_m_tvalid", {31'b0, m_tvalid}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_s_tready", {31'b0, s_tready}, 0);
        check("rst_err", {31'b0, err_short}, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("idle_cmd_ready", {31'b0, cmd_ready}, 1);

        run_frame(4'hB, 12'd100, 0, 0, -1, 1'b0, 1'b1);
        check("f1_signal", got_q[0], 32'h0B000C8B);
        check("f1_tail", got_q[1], 32'h1B000000);

        run_frame(4'hF, 12'd1, 0, 0, -1, 1'b0, 1'b0);
        check("odd_parity_sig", got_q[0], 32'h0B02002F);

        for (int n = 0; n < 50; n++)
            run_frame(rates[$urandom_range(0, 7)], 12'($urandom), 0, 0, -1, 1'b0, 1'b0);

        next_data.push_back(24'h111111);
        next_data.push_back(24'h222222);
        next_data.push_back(24'h333333);
        run_frame(4'hD, 12'd7, 3, 2, -1, 1'b0, 1'b0);
        check("f3_signal", got_q[0], 32'h0B0000ED);
        check("f3_word3", got_q[3], 32'h0D333333);
        check("f3_last", got_q[6], 32'h1D000000);
        check("f3_no_err", {31'b0, err_short}, 0);

        run_frame(4'hA, 12'd50, 5, 1, 1, 1'b0, 1'b0);
        run_frame(4'hE, 12'd9, 2, 0, -1, 1'b0, 1'b0);

        rnd_ready = 1'b1;
        for (int n = 0; n < 20; n++)
            run_frame(rates[$urandom_range(0, 7)], 12'($urandom), $urandom_range(1, 6),
                      $urandom_range(0, 3), -1, 1'b1, 1'b0);
        run_frame(4'h9, 12'd33, 6, 2, 2, 1'b1, 1'b0);
        rnd_ready = 1'b0;
        repeat (2) @(negedge aclk);
        check("stall_stable", stall_err, 0);

        send_cmd(4'hE, 12'd20, 4, 1);
        feed_word(24'hABCDEF, 1'b0);
        feed_word(24'h123456, 1'b0);
        @(negedge aclk);
        #3 aresetn = 1'b0;
        #1;
        check("arst_m_tvalid", {31'b0, m_tvalid}, 0);
        check("arst_m_tdata", {8'b0, m_tdata}, 0);
        check("arst_m_tuser", {28'b0, m_tuser}, 0);
        check("arst_m_tlast", {31'b0, m_tlast}, 0);
        check("arst_s_tready", {31'b0, s_tready}, 0);
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_cmd_ready", {31'b0, cmd_ready}, 0);
        s_tvalid = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        got_q.delete();
        next_data.push_back(24'h0F0F0F);
        next_data.push_back(24'hF0F0F0);
        run_frame(4'hC, 12'd4095, 2, 1, -1, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_frame_ctrl.md
Name: encoder_frame_ctrl

Overview:
- Frame sequencer placed directly upstream of the convolutional encoder.
- Takes one frame command per PPDU and emits the SIGNAL word at the base rate. It then forwards a counted number of scrambled data words at the commanded rate, followed by one all-zero tail word and a configurable number of zero pad words.
- Drives the encoder's tuser (rate) and tlast, so the encoder itself needs no frame awareness.
- Tail zeros flush the encoder history between frames.

Parameters:
- WIDTH, 24, data word width in bits. Must be ≥ 18 so the SIGNAL field fits in one word.
- NW_BITS, 12, width of the data word counter.
- NP_BITS, 8, width of the pad word counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  frame command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_rate  in  4  RATE code (`RATE_* from ieee80211_defs.v)
- cmd_length  in  12  PSDU length in bytes, placed into SIGNAL
- cmd_nwords  in  NW_BITS  data words to forward (SERVICE+PSDU, already scrambled)
- cmd_npad  in  NP_BITS  zero pad words after the tail word
- s_axis_tdata  in  WIDTH  data words
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1  upstream end of frame
- m_axis_tdata  out  WIDTH  to encoder
- m_axis_tuser  out  4  rate for the current word
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1  final word of frame
- busy  out  1  high in any state other than IDLE
- err_short  out  1  sticky; upstream tlast arrived before cmd_nwords words were received

Behaviour:
- Reset is asynchronous, active-low, and valid at any time, including mid-frame. Any frame in progress is abandoned with no further words emitted.
  - Outputs in reset: cmd_ready=0 while aresetn low, then 1 in IDLE; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, s_axis_tready=0, busy=0, err_short=0.
  - State returns to IDLE.
- Output register: all m_axis_* outputs are registered.
  - The register loads when it is empty or being drained: load_ok = !m_axis_tvalid || m_axis_tready.
  - Once m_axis_tvalid is high, tdata, tuser and tlast hold stable until the handshake completes.
  - Zero bubbles: back-to-back words flow at one per cycle when m_axis_tready is held high.
- States: IDLE, SIGNAL, DATA, TAIL, PAD.
- IDLE
  - cmd_ready=1.
  - On command handshake: latch rate, length, nwords and npad; clear err_short; go to SIGNAL.
- SIGNAL: when load_ok, load the SIGNAL word, then go to DATA (or TAIL if nwords==0).
  - tuser=`RATE_6M, tlast=0.
  - Bits [3:0]=rate, bit 4=0, bits [16:5]=length, bit 17=even parity (XOR of bits 0..16), bits [WIDTH-1:18]=0.
  - Bit 0 is transmitted first.
- DATA
  - s_axis_tready = load_ok.
  - Each s handshake loads s_axis_tdata with tuser=latched rate, tlast=0, and decrements the remaining count.
  - After the final counted word, go to TAIL. s_axis_tlast on that word is ignored.
  - If s_axis_tlast is seen with words still remaining:
    - set err_short;
    - stop accepting input (s_axis_tready=0);
    - emit the remaining count as zero words at load_ok, one per cycle;
    - then go to TAIL.
  - Upstream words beyond nwords are not accepted; s_axis_tready=0 outside DATA.
- TAIL
  - At load_ok, load an all-zero word with tuser=latched rate.
  - tlast=1 if npad==0, else 0.
  - Go to PAD, or to IDLE if npad==0.
- PAD
  - Each load_ok loads a zero word with tuser=latched rate.
  - The last pad word has tlast=1; then go to IDLE.
- Returning to IDLE: cmd_ready rises in the cycle after the last word loads. A new command may be accepted while that last word is still waiting for m_axis_tready.
- Latency: the SIGNAL word is valid on m_axis one cycle after the command handshake. Each forwarded data word appears one cycle after its s handshake.
- Frame length on m_axis = 1 + nwords + 1 + npad words, with exactly one tlast per frame.

Test Plan:
- Command cmd_rate=4'hB, cmd_length=100, nwords=0, npad=0, m_axis_tready=1 → exactly 2 words:
  - word 1: 0x000C8B, tuser=`RATE_6M, tlast=0;
  - word 2: 0x000000, tuser=4'hB, tlast=1.
- cmd_length=1 (odd parity case) → SIGNAL bit 17 set; verify parity over bits 0..16 for 50 random rate/length pairs.
- nwords=3, npad=2, data 0x111111/0x222222/0x333333 with upstream tlast on the third word → output sequence SIG, 0x111111, 0x222222, 0x333333, 0, 0, 0; tlast only on the 7th word; err_short=0.
- Random m_axis_tready (50%) and s_axis_tvalid gaps over 20 frames → no dropped or duplicated words, tdata/tuser/tlast stable while stalled, scoreboard match.
- nwords=5 with upstream tlast on word 2 → err_short=1; words 3–5 emitted as zeros; tail emitted; upstream stalled (s_axis_tready=0) until the next frame's DATA state; err_short clears on the next command.
- Deassert aresetn mid-DATA → all outputs at reset values immediately (asynchronous); after release a fresh command produces a correct frame starting with the SIGNAL word.
